// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, word geometry, FSM states and rcon lookup.
package aes_pkg;

    localparam int NR    = 10;
    localparam int NK    = 4;
    localparam int KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_ks_step.sv
// One AES-128 key-expansion step, forward (dir=0) or inverse (dir=1), sharing a single SubWord.
module aes_ks_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [7:0]       rc,
    input  logic             dir,
    output logic [KEY_W-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] inv_w3, sub_in, rot, sub_out, t;
    logic [31:0] f0, f1, f2, f3;

    assign {w0, w1, w2, w3} = key;

    // The inverse step needs the recovered w3 before SubWord, which lets both directions share one S-box set.
    assign inv_w3 = w3 ^ w2;
    assign sub_in = dir ? inv_w3 : w3;
    assign rot    = {sub_in[23:0], sub_in[31:24]};

    for (genvar i = 0; i < NK; i++) begin : g_sbox
        sub_byte u_sub_byte (
            .a(rot[8*i +: 8]),
            .y(sub_out[8*i +: 8])
        );
    end

    assign t  = sub_out ^ {rc, 24'h0};
    assign f0 = w0 ^ t;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign next_key = dir ? {w0 ^ t, w1 ^ w0, w2 ^ w1, inv_w3} : {f0, f1, f2, f3};

endmodule

// File: rtl/sub_byte.sv
// AES forward S-box for one byte, purely combinational.
module sub_byte (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Byte 0x00 sits in the top eight bits, so entry x lives at bit offset 8*(255-x) = {~x, 3'b000}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Decryption-order AES-128 round-key generator: expands forward to round 10, then walks back to round 0.
// Define AES_INV_KS_CACHE_EN to keep a round-10 copy so wrapping from round 0 costs no stall.
module aes_inv_key_sched #(
    parameter int NR = aes_pkg::NR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_load,
    input  logic [aes_pkg::KEY_W-1:0] key_in,
    output logic                     busy,
    output logic                     rk_valid,
    input  logic                     rk_req,
    output logic [aes_pkg::KEY_W-1:0] rk_out,
    output logic [3:0]               rk_round
);

    import aes_pkg::*;

    if (NR != 10) begin : g_bad_nr
        $error("aes_inv_key_sched supports only NR=10 (AES-128)");
    end

    state_t           state;
    logic [KEY_W-1:0] work;
    logic [KEY_W-1:0] next_key;
    logic [3:0]       cnt;
    logic [3:0]       round;
    logic             valid;
    logic             busy_q;
    logic             dir;
    logic [7:0]       rc;

    // The working register is the output register: it holds key_in at round 0 and round 10 after expansion.
    assign rk_out   = work;
    assign rk_round = round;
    assign rk_valid = valid;
    assign busy     = busy_q;

    assign dir = (state == READY);
    assign rc  = rcon(dir ? round - 4'd1 : cnt);

    aes_ks_step u_step (
        .key     (work),
        .rc      (rc),
        .dir     (dir),
        .next_key(next_key)
    );

`ifdef AES_INV_KS_CACHE_EN
    logic [KEY_W-1:0] cache;
`endif

    // NOTE: every register here is assigned with <= so all updates see the pre-edge values of their peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            round  <= '0;
            valid  <= 1'b0;
            busy_q <= 1'b0;
`ifdef AES_INV_KS_CACHE_EN
            cache  <= '0;
`endif
        end else if (key_load) begin
            work   <= key_in;
            cnt    <= '0;
            state  <= EXPAND;
            busy_q <= 1'b1;
            valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                EXPAND: begin
                    work <= next_key;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'(NR - 1)) begin
                        state  <= READY;
                        busy_q <= 1'b0;
                        valid  <= 1'b1;
                        round  <= 4'(NR);
`ifdef AES_INV_KS_CACHE_EN
                        cache  <= next_key;
`endif
                    end
                end
                READY: begin
                    if (rk_req) begin
                        if (round != 4'd0) begin
                            work  <= next_key;
                            round <= round - 4'd1;
                        end else begin
`ifdef AES_INV_KS_CACHE_EN
                            work  <= cache;
                            round <= 4'(NR);
`else
                            // Round 0 is key_in again, so a fresh forward pass rebuilds round 10.
                            state  <= EXPAND;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            valid  <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched against FIPS-197 AES-128 key-expansion vectors.
module tb_aes_inv_key_sched;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A_R9    = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] A_R8    = 128'head27321b58dbad2312bf5607f8d292f;
    localparam logic [127:0] A_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         rk_valid;
    logic         rk_req = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk     (clk),
        .rst     (rst),
        .key_load(key_load),
        .key_in  (key_in),
        .busy    (busy),
        .rk_valid(rk_valid),
        .rk_req  (rk_req),
        .rk_out  (rk_out),
        .rk_round(rk_round)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_key(input logic [127:0] k);
        key_load = 1'b1;
        key_in   = k;
        step();
        key_load = 1'b0;
    endtask

    // Counts edges until rk_valid rises; also reports whether busy stayed high throughout.
    task automatic wait_valid(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!rk_valid && n < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            n++;
        end
    endtask

    int   lat;
    logic bok;

    initial begin
        // Asynchronous reset with no clock edge in between.
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", {127'b0, rk_valid}, 128'd0);
        check("rst_async_busy",  {127'b0, busy}, 128'd0);
        check("rst_async_out",   rk_out, 128'd0);
        check("rst_async_round", {124'b0, rk_round}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step();
        check("idle_valid", {127'b0, rk_valid}, 128'd0);
        check("idle_busy",  {127'b0, busy}, 128'd0);

        // Forward expansion of the FIPS-197 key.
        load_key(KEY_A);
        check("load_busy",  {127'b0, busy}, 128'd1);
        check("load_valid", {127'b0, rk_valid}, 128'd0);
        wait_valid(lat, bok);
        check("expand_latency", 128'(lat), 128'd10);
        check("expand_busy_held", {127'b0, bok}, 128'd1);
        check("ready_busy",  {127'b0, busy}, 128'd0);
        check("r10_round", {124'b0, rk_round}, 128'd10);
        check("r10_key",   rk_out, A_R10);

        // Ten consecutive requests walk back to the original key.
        rk_req = 1'b1;
        for (int r = 9; r >= 0; r--) begin
            step();
            if (r == 9) check("r9_key", rk_out, A_R9);
            if (r == 8) check("r8_key", rk_out, A_R8);
            if (r == 1) check("r1_key", rk_out, A_R1);
        end
        rk_req = 1'b0;
        check("r0_round", {124'b0, rk_round}, 128'd0);
        check("r0_key",   rk_out, KEY_A);
        check("r0_valid", {127'b0, rk_valid}, 128'd1);
        step();
        check("hold_round", {124'b0, rk_round}, 128'd0);
        check("hold_key",   rk_out, KEY_A);

        // Wrap from round 0.
        rk_req = 1'b1;
        step();
        rk_req = 1'b0;
`ifdef AES_INV_KS_CACHE_EN
        check("wrap_valid", {127'b0, rk_valid}, 128'd1);
        check("wrap_busy",  {127'b0, busy}, 128'd0);
`else
        check("wrap_valid", {127'b0, rk_valid}, 128'd0);
        check("wrap_busy",  {127'b0, busy}, 128'd1);
        wait_valid(lat, bok);
        check("wrap_latency", 128'(lat), 128'd10);
`endif
        check("wrap_round", {124'b0, rk_round}, 128'd10);
        check("wrap_key",   rk_out, A_R10);

        // A second load mid-expansion restarts it, and rk_req is ignored meanwhile.
        load_key(KEY_A);
        for (int i = 0; i < 3; i++) begin
            rk_req = ~rk_req;
            step();
        end
        rk_req = 1'b1;
        load_key(128'd0);
        rk_req = 1'b0;
        check("restart_valid", {127'b0, rk_valid}, 128'd0);
        wait_valid(lat, bok);
        check("restart_latency", 128'(lat), 128'd10);
        check("restart_round", {124'b0, rk_round}, 128'd10);
        check("restart_key",   rk_out, ZERO_R10);

        // Walk to round 5, then reset asynchronously mid-cycle.
        rk_req = 1'b1;
        repeat (5) step();
        rk_req = 1'b0;
        check("r5_round", {124'b0, rk_round}, 128'd5);
        #2 rst = 1'b1;
        #1;
        check("rst_ready_valid", {127'b0, rk_valid}, 128'd0);
        check("rst_ready_out",   rk_out, 128'd0);
        check("rst_ready_round", {124'b0, rk_round}, 128'd0);
        check("rst_ready_busy",  {127'b0, busy}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        rk_req = 1'b1;
        repeat (3) step();
        rk_req = 1'b0;
        check("post_rst_req_valid", {127'b0, rk_valid}, 128'd0);
        check("post_rst_req_round", {124'b0, rk_round}, 128'd0);
        check("post_rst_req_out",   rk_out, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
